// File: rtl/dmem_mmio_bridge.sv
// Data-memory bridge: word RAM plus an MMIO page with a TX FIFO,
// a status register and a writable free-running cycle counter.
module dmem_mmio_bridge #(
    parameter int RAM_WORDS  = 256,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dmem_we,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] DEPTH = (PW + 1)'(FIFO_DEPTH);

    logic [31:0]   ram_q  [RAM_WORDS];
    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   cyc_q, cyc_d;

    logic          is_mmio;
    logic [AW-1:0] ram_idx;
    logic [13:0]   reg_idx;
    logic          sel_tx, sel_st, sel_cyc;
    logic          full, pop, push_req, push;
    logic          unused;

    assign is_mmio = dmem_addr[31:16] == 16'hFFFF;
    assign ram_idx = dmem_addr[AW+1:2];
    assign reg_idx = dmem_addr[15:2];
    assign unused  = ^dmem_addr[1:0];

    assign sel_tx  = is_mmio && reg_idx == 14'd0;
    assign sel_st  = is_mmio && reg_idx == 14'd1;
    assign sel_cyc = is_mmio && reg_idx == 14'd2;

    assign full      = cnt_q == DEPTH;
    assign out_valid = cnt_q != '0;
    assign out_data  = fifo_q[rd_ptr_q];
    assign pop       = out_valid && out_ready;
    assign push_req  = !rst && dmem_we && sel_tx;
    // A full FIFO still accepts a byte when the head leaves in the same cycle
    assign push      = push_req && (!full || pop);

    always_ff @(posedge clk) begin
        if (dmem_we && !is_mmio) ram_q[ram_idx] <= dmem_wdata;
        if (push) fifo_q[wr_ptr_q] <= dmem_wdata[7:0];
    end

    always_comb begin
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        cnt_d    = cnt_q;
        if (push && !pop) cnt_d = cnt_q + 1'b1;
        if (pop && !push) cnt_d = cnt_q - 1'b1;
        ovf_d = ovf_q;
        if (dmem_we && sel_st && dmem_wdata[2]) ovf_d = 1'b0;
        if (push_req && !push) ovf_d = 1'b1;
        cyc_d = (dmem_we && sel_cyc) ? dmem_wdata : cyc_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            cyc_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            cyc_q    <= cyc_d;
        end
    end

    always_comb begin
        dmem_rdata = '0;
        if (!is_mmio) begin
            dmem_rdata = ram_q[ram_idx];
        end else if (sel_st) begin
            dmem_rdata = {16'h0, 8'(cnt_q), 5'h0, ovf_q, full, !out_valid};
        end else if (sel_cyc) begin
            dmem_rdata = cyc_q;
        end
    end
endmodule

// File: tb/tb_dmem_mmio_bridge.sv
// Directed testbench for dmem_mmio_bridge (RAM_WORDS=256, FIFO_DEPTH=8).
module tb_dmem_mmio_bridge;
    logic        clk = 1'b0;
    logic        rst;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;

    int pass_cnt = 0;
    int total = 0;

    localparam logic [31:0] TX  = 32'hFFFF0000;
    localparam logic [31:0] ST  = 32'hFFFF0004;
    localparam logic [31:0] CYC = 32'hFFFF0008;

    dmem_mmio_bridge #(.RAM_WORDS(256), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        dmem_we = 1'b1; dmem_addr = a; dmem_wdata = d;
        tick();
        dmem_we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        dmem_we = 1'b0; dmem_addr = a;
        #1;
        d = dmem_rdata;
    endtask

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp)
            $display("FAIL %s: got %08h expected %08h", name, got, exp);
        else
            pass_cnt++;
    endtask

    task automatic do_reset();
        rst = 1'b1; out_ready = 1'b0; dmem_we = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        do_reset();
        chk("reset_valid", {31'b0, out_valid}, 32'd0);
        rd(ST, d);  chk("reset_status", d, 32'h00000001);
        rd(TX, d);  chk("txdata_read", d, 32'h0);
        rd(32'hFFFF0010, d); chk("unmapped_read", d, 32'h0);
    endtask

    task automatic test_ram();
        logic [31:0] d;
        wr(32'h10, 32'hDEADBEEF);
        wr(32'h14, 32'h12345678);
        rd(32'h10, d);  chk("ram_10", d, 32'hDEADBEEF);
        rd(32'h14, d);  chk("ram_14", d, 32'h12345678);
        rd(32'h410, d); chk("ram_alias", d, 32'hDEADBEEF);
        rd(32'h13, d);  chk("ram_lowbits", d, 32'hDEADBEEF);
    endtask

    task automatic test_fifo_basic();
        logic [31:0] d;
        do_reset();
        wr(TX, 32'h41);
        wr(TX, 32'h42);
        wr(TX, 32'h43);
        wr(32'hFFFF0010, 32'h55);
        wr(32'h20, 32'h77);
        rd(ST, d); chk("basic_status", d, 32'h00000300);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("basic_valid", {31'b0, out_valid}, 32'd1);
            chk("basic_data", {24'b0, out_data}, 32'h41 + i);
            tick();
        end
        out_ready = 1'b0;
        chk("basic_empty", {31'b0, out_valid}, 32'd0);
        rd(ST, d); chk("basic_status_end", d, 32'h00000001);
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        do_reset();
        for (int i = 0; i < 9; i++) wr(TX, i);
        rd(ST, d); chk("ovf_status", d, 32'h00000806);
        wr(ST, 32'h3);
        rd(ST, d); chk("ovf_noclear", d, 32'h00000806);
        wr(ST, 32'h4);
        rd(ST, d); chk("ovf_clear", d, 32'h00000802);
        chk("ovf_stable", {24'b0, out_data}, 32'h00);
        tick();
        chk("ovf_stable2", {24'b0, out_data}, 32'h00);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("ovf_drain", {24'b0, out_data}, i);
            tick();
        end
        out_ready = 1'b0;
        chk("ovf_drained", {31'b0, out_valid}, 32'd0);
    endtask

    task automatic test_full_pushpop();
        logic [31:0] d;
        do_reset();
        for (int i = 0; i < 8; i++) wr(TX, 32'h10 + i);
        out_ready = 1'b1;
        wr(TX, 32'h99);
        out_ready = 1'b0;
        rd(ST, d); chk("pp_status", d, 32'h00000802);
        out_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            chk("pp_drain", {24'b0, out_data}, 32'h10 + i);
            tick();
        end
        chk("pp_last", {24'b0, out_data}, 32'h99);
        tick();
        out_ready = 1'b0;
        chk("pp_empty", {31'b0, out_valid}, 32'd0);
    endtask

    task automatic test_cycle();
        logic [31:0] d;
        do_reset();
        rd(CYC, d); chk("cyc_0", d, 32'd0);
        tick();
        rd(CYC, d); chk("cyc_1", d, 32'd1);
        repeat (5) tick();
        rd(CYC, d); chk("cyc_6", d, 32'd6);
        wr(CYC, 32'hFFFFFFFE);
        rd(CYC, d); chk("cyc_fffe", d, 32'hFFFFFFFE);
        tick();
        rd(CYC, d); chk("cyc_ffff", d, 32'hFFFFFFFF);
        tick();
        rd(CYC, d); chk("cyc_wrap", d, 32'h0);
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        do_reset();
        wr(32'h20, 32'hCAFEF00D);
        for (int i = 0; i < 9; i++) wr(TX, 32'h60 + i);
        out_ready = 1'b1;
        repeat (3) tick();
        out_ready = 1'b0;
        rd(ST, d); chk("mid_status", d, 32'h00000504);
        rst = 1'b1; out_ready = 1'b1;
        wr(TX, 32'hAA);
        rst = 1'b0; out_ready = 1'b0;
        chk("mid_valid", {31'b0, out_valid}, 32'd0);
        rd(ST, d);   chk("mid_st", d, 32'h00000001);
        rd(CYC, d);  chk("mid_cyc", d, 32'd0);
        rd(32'h20, d); chk("mid_ram", d, 32'hCAFEF00D);
        tick();
        rd(CYC, d);  chk("mid_cyc1", d, 32'd1);
        rd(ST, d);   chk("mid_st1", d, 32'h00000001);
    endtask

    initial begin
        rst = 1'b1; dmem_we = 1'b0; dmem_addr = '0;
        dmem_wdata = '0; out_ready = 1'b0;
        tick();
        test_reset();
        test_ram();
        test_fifo_basic();
        test_overflow();
        test_full_pushpop();
        test_cycle();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/dmem_mmio_bridge.md
Name: dmem_mmio_bridge

Overview:
- Data-memory subsystem that consumes the processor's dmem-side bus (we/addr/wdata) and returns rdata in the same cycle.
- Decodes each access to one of two targets: a word-addressed data RAM, or a memory-mapped peripheral page.
- The peripheral page holds a byte-wide transmit FIFO with a valid/ready output port, a status register and a writable free-running cycle counter.
- Sits directly downstream of the single-cycle core; a console/LED consumer drains the FIFO.

Parameters:
- RAM_WORDS, 256, data RAM depth in 32-bit words; power of two, ≥ 4.
- FIFO_DEPTH, 8, transmit FIFO depth in bytes; power of two, 2 to 128.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- dmem_we  input  1  write strobe from the core for the current cycle.
- dmem_addr  input  32  byte address; bits [1:0] are ignored (word access only).
- dmem_wdata  input  32  write data.
- dmem_rdata  output  32  read data; combinational from dmem_addr and current state.
- out_valid  output  1  FIFO non-empty.
- out_data  output  8  FIFO head byte; meaningful only when out_valid=1.
- out_ready  input  1  consumer accepts the head byte this cycle.

Behaviour:
- Decode:
  - MMIO when dmem_addr[31:16]==16'hFFFF.
  - Otherwise RAM, indexed by dmem_addr[log2(RAM_WORDS)+1:2]. Higher address bits are ignored, so the RAM aliases modulo its size.
- RAM:
  - Asynchronous read.
  - Write on the clock edge when dmem_we=1.
  - Contents are not reset; reads before the first write are undefined.
- MMIO registers (decoded on addr[15:2]):
  - 0xFFFF0000 TXDATA.
    - Write pushes wdata[7:0] into the FIFO.
    - Reads return 0.
  - 0xFFFF0004 STATUS.
    - Read layout: bit0=empty, bit1=full, bit2=overflow (sticky), bits[15:8]=occupancy count, all other bits 0.
    - Writing with wdata[2]=1 clears overflow (write-1-to-clear). Other written bits are ignored.
  - 0xFFFF0008 CYCLE.
    - Read returns the current counter value.
    - A write in cycle N makes the counter equal wdata in cycle N+1. Counting then resumes from that value.
  - Any other MMIO address: read 0, writes ignored. Non-MMIO and non-TXDATA accesses never affect the FIFO.
- Cycle counter:
  - 32-bit; reset to 0.
  - +1 every cycle; wraps 0xFFFFFFFF→0.
  - A write takes priority over the increment.
- FIFO:
  - Circular buffer with wrapping read/write pointers and an occupancy count (0..FIFO_DEPTH).
  - Pop when out_valid && out_ready.
  - Push when a TXDATA write occurs and (count<FIFO_DEPTH or a pop occurs in the same cycle).
    - Push+pop on a full FIFO: both happen and the count stays FIFO_DEPTH.
  - Push+pop at any other occupancy: the count is unchanged and the pointers advance.
  - TXDATA write while full with no pop: byte dropped, overflow set to 1, FIFO unchanged.
  - Overflow set and overflow clear in the same cycle: set wins.
  - Empty FIFO: out_valid=0. A same-cycle push is not visible until the next cycle (no fall-through).
  - out_data = storage[rd_ptr], registered storage, stable while out_valid && !out_ready.
- Reset (synchronous, any cycle including mid-transfer):
  - FIFO emptied, pointers 0, count 0, overflow 0, CYCLE 0.
  - out_valid=0 on the cycle after rst is sampled high.
  - RAM contents are kept.
  - A write presented in a reset cycle is ignored for MMIO state.
- Outputs after reset:
  - out_valid=0.
  - dmem_rdata follows decode: STATUS reads 0x00000001.
  - out_data is don't-care.

Test Plan:
- RAM: write 0xDEADBEEF @0x10, then 0x12345678 @0x14; read @0x10 → 0xDEADBEEF, @0x14 → 0x12345678. With RAM_WORDS=256, read @0x410 (alias) → 0xDEADBEEF.
- FIFO basic: out_ready=0; write 0x41, 0x42, 0x43 to 0xFFFF0000. STATUS reads 0x00000300. Raise out_ready → out_data 0x41, 0x42, 0x43 on consecutive cycles. Then out_valid=0 and STATUS reads 0x00000001.
- Full/overflow: out_ready=0; push 9 bytes (0x00..0x08) into depth 8.
  - STATUS = 0x00000806; byte 0x08 is lost.
  - Write 0x4 to STATUS → 0x00000802.
  - Drain yields 0x00..0x07.
- Full push+pop: fill 8 bytes, then in one cycle out_ready=1 and write 0x99 → no overflow, count stays 8; 0x99 emerges last.
- CYCLE: after reset, read at cycle k → k. Write 0xFFFFFFFE → reads 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000 on the next three cycles.
- Reset mid-operation: with 5 bytes queued and overflow set, pulse rst one cycle → out_valid=0, STATUS=0x00000001, CYCLE restarts at 0, previously written RAM word unchanged.
